stepper_phase_decoder: RTL and testbench

STEPPER_PHASE_DECODER -- requirements
Module: stepper_phase_decoder

---
 rtl/stepper_pkg.sv | 51 +++++
 rtl/stepper_phase_decoder_if.sv | 39 +++
 rtl/stepper_glitch_filter.sv | 76 +++++++
 rtl/stepper_phase_decoder.sv | 201 ++++++++++++++++++++
 tb/tb_stepper_phase_decoder.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/stepper_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stepper_pkg
//  Description : Shared definitions for the stepper phase decoder.
//                - the coil phase-pattern table (same table the motor driver
//                  uses)
//                - the decoder FSM state enum
//                - default parameter constants
//                - a helper that classifies a coil pattern
//  Revision    : 1.0 - initial release
// ============================================================================
package stepper_pkg;

    // Default parameter values
    localparam int c_default_stable_cycles = 4;
    localparam int c_default_pos_width     = 16;
    localparam int c_default_period_width  = 20;

    // Coil patterns: phase index i energises coil bit i only
    localparam logic [3:0]      c_pattern_off   = 4'b0000;
    localparam logic [3:0][3:0] c_phase_pattern = {4'b1000, 4'b0100, 4'b0010, 4'b0001};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,   // no phase known
        ST_LOCKED = 2'd1,   // phase known, steps are tracked
        ST_FAULT  = 2'd2    // sticky until fault_clr
    } state_t;

    typedef struct packed {
        logic       legal;      // one of the five recognised patterns
        logic       energised;  // exactly one coil driven
        logic [1:0] idx;        // phase index when energised
    } phase_decode_t;

    function automatic phase_decode_t decode_pattern(input logic [3:0] pattern);
        phase_decode_t d;
        d.legal     = (pattern == c_pattern_off);
        d.energised = 1'b0;
        d.idx       = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (pattern == c_phase_pattern[i]) begin
                d.legal     = 1'b1;
                d.energised = 1'b1;
                d.idx       = 2'(i);
            end
        end
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stepper_phase_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : stepper_phase_decoder_if
//  Description : Signal bundle between a coil-observing client and the
//                stepper phase decoder.
//                master : drives coils / fault_clr, observes decoder status
//                slave  : the decoder side
//                Signals: coils[3:0], fault_clr, step_pulse, dir,
//                position[POS_WIDTH-1:0] (signed), phase_idx[1:0], enabled,
//                fault, step_period[PERIOD_WIDTH-1:0]
//  Revision    : 1.0 - initial release
// ============================================================================
interface stepper_phase_decoder_if
    import stepper_pkg::*;
#(
    parameter int POS_WIDTH    = c_default_pos_width,
    parameter int PERIOD_WIDTH = c_default_period_width
);
    logic [3:0]                  coils;
    logic                        fault_clr;
    logic                        step_pulse;
    logic                        dir;
    logic signed [POS_WIDTH-1:0] position;
    logic [1:0]                  phase_idx;
    logic                        enabled;
    logic                        fault;
    logic [PERIOD_WIDTH-1:0]     step_period;

    modport master (
        output coils, fault_clr,
        input  step_pulse, dir, position, phase_idx, enabled, fault, step_period
    );

    modport slave (
        input  coils, fault_clr,
        output step_pulse, dir, position, phase_idx, enabled, fault, step_period
    );
endinterface
`default_nettype wire

// File: rtl/stepper_glitch_filter.sv
`default_nettype none
// ============================================================================
//  Module      : stepper_glitch_filter
//  Description : Registers the coil inputs once and counts how many
//                consecutive edges sampled the same pattern. When a pattern
//                has been seen STABLE_CYCLES times and differs from the last
//                accepted pattern, a one-cycle accept strobe is emitted with
//                the pattern.
//  Ports       : clk, rst       - clock, synchronous active-high reset
//                i_coils[3:0]   - raw coil pattern
//                i_clear        - drop the count and forget the last accepted
//                                 pattern (so a held pattern is re-accepted)
//                o_accept       - one-cycle strobe, new pattern accepted
//                o_pattern[3:0] - the accepted pattern
//  Revision    : 1.0 - initial release
// ============================================================================
module stepper_glitch_filter
    import stepper_pkg::*;
#(
    parameter int STABLE_CYCLES = c_default_stable_cycles
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] i_coils,
    input  logic       i_clear,
    output logic       o_accept,
    output logic [3:0] o_pattern
);

    localparam logic [7:0] c_stable_target = 8'(STABLE_CYCLES);

    logic [3:0] r_sample;
    logic [7:0] r_stable_cnt;
    logic [3:0] r_accepted;
    logic       r_accept;

    logic w_stable;
    logic w_new;

    assign w_stable = (r_stable_cnt == c_stable_target);
    assign w_new    = (r_sample != r_accepted);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sample     <= 4'b0000;
            r_stable_cnt <= 8'd0;
            r_accepted   <= 4'b0000;
            r_accept     <= 1'b0;
        end else begin
            r_sample <= i_coils;
            if (i_clear) begin
                r_stable_cnt <= 8'd0;
                r_accepted   <= 4'b0000;
                r_accept     <= 1'b0;
            end else begin
                // The edge that first samples a new pattern counts as one.
                if (i_coils != r_sample) begin
                    r_stable_cnt <= 8'd1;
                end else if (!w_stable) begin
                    r_stable_cnt <= r_stable_cnt + 8'd1;
                end
                // r_sample held STABLE_CYCLES samples, even if the raw input
                // has just moved on.
                r_accept <= w_stable && w_new;
                if (w_stable && w_new) begin
                    r_accepted <= r_sample;
                end
            end
        end
    end

    assign o_accept  = r_accept;
    assign o_pattern = r_accepted;

endmodule
`default_nettype wire

// File: rtl/stepper_phase_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : stepper_phase_decoder
//  Description : Watches the coil drive of a 4-phase stepper, filters it,
//                and tracks phase, direction, signed position and the
//                period between steps. Skipped steps and illegal patterns
//                latch a sticky fault that is released by fault_clr.
//  Ports       : system1000      - clock, rising edge
//                system1000_rst  - synchronous active-high reset
//                bus (slave)     - coils, fault_clr in; step_pulse, dir,
//                                  position, phase_idx, enabled, fault,
//                                  step_period out
//  Revision    : 1.0 - initial release
// ============================================================================
module stepper_phase_decoder
    import stepper_pkg::*;
#(
    parameter int STABLE_CYCLES = c_default_stable_cycles,
    parameter int POS_WIDTH     = c_default_pos_width,
    parameter int PERIOD_WIDTH  = c_default_period_width
) (
    input  logic                  system1000,
    input  logic                  system1000_rst,
    stepper_phase_decoder_if.slave bus
);

    localparam logic [PERIOD_WIDTH-1:0] c_period_max = '1;

    // Registered state and outputs
    state_t                  r_state;
    logic                    r_step_pulse;
    logic                    r_dir;
    logic [POS_WIDTH-1:0]    r_position;
    logic [1:0]              r_phase_idx;
    logic                    r_enabled;
    logic                    r_fault;
    logic [PERIOD_WIDTH-1:0] r_step_period;
    logic [PERIOD_WIDTH-1:0] r_period_cnt;

    // Next-state values
    state_t                  w_state_nxt;
    logic                    w_step_pulse_nxt;
    logic                    w_dir_nxt;
    logic [POS_WIDTH-1:0]    w_position_nxt;
    logic [1:0]              w_phase_idx_nxt;
    logic                    w_enabled_nxt;
    logic                    w_fault_nxt;
    logic [PERIOD_WIDTH-1:0] w_step_period_nxt;
    logic [PERIOD_WIDTH-1:0] w_period_cnt_nxt;

    logic                    w_accept;
    logic [3:0]              w_pattern;
    phase_decode_t           w_decoded;
    logic [1:0]              w_idx_delta;
    logic                    w_step;
    logic                    w_filter_clear;
    logic [PERIOD_WIDTH-1:0] w_period_cnt_inc;

    stepper_glitch_filter #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk       (system1000),
        .rst       (system1000_rst),
        .i_coils   (bus.coils),
        .i_clear   (w_filter_clear),
        .o_accept  (w_accept),
        .o_pattern (w_pattern)
    );

    assign w_decoded   = decode_pattern(w_pattern);
    // Modulo-4 distance: 1 = forward, 3 = reverse, 2 = a skipped step
    assign w_idx_delta = w_decoded.idx - r_phase_idx;
    assign w_period_cnt_inc = (r_period_cnt == c_period_max) ? c_period_max
                                                             : r_period_cnt + PERIOD_WIDTH'(1);

    always_comb begin
        w_state_nxt       = r_state;
        w_step_pulse_nxt  = 1'b0;
        w_dir_nxt         = r_dir;
        w_position_nxt    = r_position;
        w_phase_idx_nxt   = r_phase_idx;
        w_enabled_nxt     = r_enabled;
        w_fault_nxt       = r_fault;
        w_step_period_nxt = r_step_period;
        w_period_cnt_nxt  = r_period_cnt;
        w_filter_clear    = 1'b0;
        w_step            = 1'b0;

        if (r_state == ST_LOCKED) begin
            w_period_cnt_nxt = w_period_cnt_inc;
        end

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (!w_decoded.legal) begin
                        w_state_nxt   = ST_FAULT;
                        w_fault_nxt   = 1'b1;
                        w_enabled_nxt = 1'b0;
                    end else if (w_decoded.energised) begin
                        w_state_nxt      = ST_LOCKED;
                        w_phase_idx_nxt  = w_decoded.idx;
                        w_enabled_nxt    = 1'b1;
                        w_period_cnt_nxt = '0;
                    end else begin
                        w_enabled_nxt = 1'b0;
                    end
                end
            end

            ST_LOCKED: begin
                if (w_accept) begin
                    if (!w_decoded.legal) begin
                        w_state_nxt   = ST_FAULT;
                        w_fault_nxt   = 1'b1;
                        w_enabled_nxt = 1'b0;
                    end else if (!w_decoded.energised) begin
                        w_state_nxt   = ST_IDLE;
                        w_enabled_nxt = 1'b0;
                    end else begin
                        case (w_idx_delta)
                            2'd1: begin
                                w_step         = 1'b1;
                                w_dir_nxt      = 1'b1;
                                w_position_nxt = r_position + POS_WIDTH'(1);
                            end
                            2'd3: begin
                                w_step         = 1'b1;
                                w_dir_nxt      = 1'b0;
                                w_position_nxt = r_position - POS_WIDTH'(1);
                            end
                            2'd2: begin
                                w_state_nxt   = ST_FAULT;
                                w_fault_nxt   = 1'b1;
                                w_enabled_nxt = 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
            end

            ST_FAULT: begin
                // Coil activity is ignored until the fault is cleared.
                if (bus.fault_clr) begin
                    w_state_nxt    = ST_IDLE;
                    w_fault_nxt    = 1'b0;
                    w_enabled_nxt  = 1'b0;
                    w_filter_clear = 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // A step publishes the elapsed period (counter + 1) and restarts
        // the counter.
        if (w_step) begin
            w_step_pulse_nxt  = 1'b1;
            w_phase_idx_nxt   = w_decoded.idx;
            w_step_period_nxt = w_period_cnt_inc;
            w_period_cnt_nxt  = '0;
        end
    end

    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            r_state       <= ST_IDLE;
            r_step_pulse  <= 1'b0;
            r_dir         <= 1'b0;
            r_position    <= '0;
            r_phase_idx   <= 2'd0;
            r_enabled     <= 1'b0;
            r_fault       <= 1'b0;
            r_step_period <= '0;
            r_period_cnt  <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_step_pulse  <= w_step_pulse_nxt;
            r_dir         <= w_dir_nxt;
            r_position    <= w_position_nxt;
            r_phase_idx   <= w_phase_idx_nxt;
            r_enabled     <= w_enabled_nxt;
            r_fault       <= w_fault_nxt;
            r_step_period <= w_step_period_nxt;
            r_period_cnt  <= w_period_cnt_nxt;
        end
    end

    assign bus.step_pulse  = r_step_pulse;
    assign bus.dir         = r_dir;
    assign bus.position    = r_position;
    assign bus.phase_idx   = r_phase_idx;
    assign bus.enabled     = r_enabled;
    assign bus.fault       = r_fault;
    assign bus.step_period = r_step_period;

endmodule
`default_nettype wire

// File: tb/tb_stepper_phase_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stepper_phase_decoder
//  Description : Self-checking bench for stepper_phase_decoder. Each coil
//                change that should produce a step pushes the expected step
//                (cycle, dir, position, phase) to a scoreboard; a monitor
//                pops and compares on every step_pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stepper_phase_decoder;

    localparam int STABLE = 4;

    typedef struct {
        int          due;
        logic        dir;
        logic [15:0] pos;
        logic [1:0]  idx;
    } step_exp_t;

    logic      clk = 1'b0;
    logic      rst = 1'b1;
    int        cyc = 0;
    int        n_checks = 0;
    int        n_pass = 0;
    int        n_pulses = 0;
    step_exp_t sb[$];
    step_exp_t mon_e;

    stepper_phase_decoder_if #(.POS_WIDTH(16), .PERIOD_WIDTH(20)) bus ();

    stepper_phase_decoder #(
        .STABLE_CYCLES (STABLE),
        .POS_WIDTH     (16),
        .PERIOD_WIDTH  (20)
    ) dut (
        .system1000     (clk),
        .system1000_rst (rst),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every pulse must match the oldest expected step.
    always @(negedge clk) begin
        if (bus.step_pulse === 1'b1) begin
            n_pulses++;
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_step: pulse at cycle %0d pos=%0h idx=%0d, required no pulse",
                         cyc, bus.position, bus.phase_idx);
            end else begin
                mon_e = sb.pop_front();
                if (cyc !== mon_e.due || bus.dir !== mon_e.dir ||
                    bus.position !== mon_e.pos || bus.phase_idx !== mon_e.idx)
                    $display("FAIL step_event: got cycle=%0d dir=%0b pos=%0h idx=%0d, required cycle=%0d dir=%0b pos=%0h idx=%0d",
                             cyc, bus.dir, bus.position, bus.phase_idx,
                             mon_e.due, mon_e.dir, mon_e.pos, mon_e.idx);
                else
                    n_pass++;
            end
        end
    end

    // Input changes happen at a negedge; the first sampling edge follows,
    // and the pulse is visible STABLE+1 edges after that one.
    task automatic expect_step(input logic d, input logic [15:0] pos, input logic [1:0] idx);
        sb.push_back('{cyc + STABLE + 2, d, pos, idx});
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        bus.coils     = 4'b0000;
        bus.fault_clr = 1'b0;
        rst = 1'b1;
        wait_cycles(2);
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({bus.step_pulse, bus.dir, bus.position, bus.phase_idx, bus.enabled, bus.fault, bus.step_period} !== 42'd0)
            $display("FAIL reset_outputs: got %0h, required 0",
                     {bus.step_pulse, bus.dir, bus.position, bus.phase_idx, bus.enabled, bus.fault, bus.step_period});
        else n_pass++;
    endtask

    task automatic test_lock();
        bus.coils = 4'b0001;
        wait_cycles(10);
        n_checks++; if (bus.enabled !== 1'b1) $display("FAIL lock_enabled: got %0b, required 1", bus.enabled); else n_pass++;
        n_checks++; if (bus.phase_idx !== 2'd0) $display("FAIL lock_phase: got %0d, required 0", bus.phase_idx); else n_pass++;
        n_checks++; if (bus.position !== 16'd0) $display("FAIL lock_position: got %0h, required 0", bus.position); else n_pass++;
        n_checks++; if (n_pulses !== 0) $display("FAIL lock_no_pulse: got %0d pulses, required 0", n_pulses); else n_pass++;
    endtask

    task automatic test_forward();
        int p0;
        logic [3:0] pats [4];
        pats = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        p0 = n_pulses;
        for (int k = 0; k < 4; k++) begin
            bus.coils = pats[k];
            expect_step(1'b1, 16'(k + 1), 2'((k + 1) % 4));
            wait_cycles(8);
        end
        n_checks++; if (n_pulses - p0 !== 4) $display("FAIL fwd_pulse_count: got %0d, required 4", n_pulses - p0); else n_pass++;
        n_checks++; if (bus.position !== 16'd4) $display("FAIL fwd_position: got %0h, required 4", bus.position); else n_pass++;
        n_checks++; if (bus.dir !== 1'b1) $display("FAIL fwd_dir: got %0b, required 1", bus.dir); else n_pass++;
        n_checks++; if (sb.size() !== 0) $display("FAIL fwd_missing: got %0d pending, required 0", sb.size()); else n_pass++;
    endtask

    task automatic test_reverse();
        do_reset();
        bus.coils = 4'b0001;
        wait_cycles(10);
        bus.coils = 4'b1000;
        expect_step(1'b0, 16'hFFFF, 2'd3);
        wait_cycles(8);
        n_checks++; if (bus.position !== 16'hFFFF) $display("FAIL rev_position: got %0h, required ffff", bus.position); else n_pass++;
        n_checks++; if (bus.dir !== 1'b0) $display("FAIL rev_dir: got %0b, required 0", bus.dir); else n_pass++;
        n_checks++; if (sb.size() !== 0) $display("FAIL rev_missing: got %0d pending, required 0", sb.size()); else n_pass++;
    endtask

    task automatic test_bounce();
        int p0;
        do_reset();
        bus.coils = 4'b0001;
        wait_cycles(10);
        p0 = n_pulses;
        bus.coils = 4'b0010;
        wait_cycles(2);
        bus.coils = 4'b0001;
        wait_cycles(12);
        n_checks++; if (n_pulses !== p0) $display("FAIL bounce_pulse: got %0d pulses, required 0", n_pulses - p0); else n_pass++;
        n_checks++; if (bus.position !== 16'd0) $display("FAIL bounce_position: got %0h, required 0", bus.position); else n_pass++;
        n_checks++; if (bus.phase_idx !== 2'd0) $display("FAIL bounce_phase: got %0d, required 0", bus.phase_idx); else n_pass++;
    endtask

    task automatic test_fault();
        int p0;
        bus.coils = 4'b0010;
        expect_step(1'b1, 16'd1, 2'd1);
        wait_cycles(8);
        p0 = n_pulses;
        bus.coils = 4'b1000;          // idx 1 -> 3 skips a step
        wait_cycles(8);
        n_checks++; if (bus.fault !== 1'b1) $display("FAIL skip_fault: got %0b, required 1", bus.fault); else n_pass++;
        n_checks++; if (bus.enabled !== 1'b0) $display("FAIL skip_enabled: got %0b, required 0", bus.enabled); else n_pass++;
        n_checks++; if (bus.position !== 16'd1) $display("FAIL skip_position: got %0h, required 1", bus.position); else n_pass++;
        bus.coils = 4'b0001;
        wait_cycles(8);
        bus.coils = 4'b0100;
        wait_cycles(8);
        n_checks++; if (bus.fault !== 1'b1 || bus.position !== 16'd1 || n_pulses !== p0)
            $display("FAIL fault_sticky: got fault=%0b pos=%0h pulses=%0d, required fault=1 pos=1 pulses=0",
                     bus.fault, bus.position, n_pulses - p0);
        else n_pass++;
        bus.fault_clr = 1'b1;
        @(negedge clk);
        bus.fault_clr = 1'b0;
        n_checks++; if (bus.fault !== 1'b0 || bus.enabled !== 1'b0)
            $display("FAIL fault_clear: got fault=%0b enabled=%0b, required 0 0", bus.fault, bus.enabled);
        else n_pass++;
        wait_cycles(10);
        n_checks++; if (bus.enabled !== 1'b1 || bus.phase_idx !== 2'd2 || bus.position !== 16'd1 || n_pulses !== p0)
            $display("FAIL relock: got en=%0b idx=%0d pos=%0h pulses=%0d, required en=1 idx=2 pos=1 pulses=0",
                     bus.enabled, bus.phase_idx, bus.position, n_pulses - p0);
        else n_pass++;
    endtask

    task automatic test_illegal();
        bus.coils = 4'b0011;
        wait_cycles(8);
        n_checks++; if (bus.fault !== 1'b1 || bus.enabled !== 1'b0)
            $display("FAIL illegal_fault: got fault=%0b enabled=%0b, required 1 0", bus.fault, bus.enabled);
        else n_pass++;
        bus.coils = 4'b0000;
        bus.fault_clr = 1'b1;
        @(negedge clk);
        bus.fault_clr = 1'b0;
        wait_cycles(10);
        n_checks++; if (bus.fault !== 1'b0 || bus.enabled !== 1'b0 || bus.position !== 16'd1)
            $display("FAIL illegal_recover: got fault=%0b en=%0b pos=%0h, required 0 0 1",
                     bus.fault, bus.enabled, bus.position);
        else n_pass++;
    endtask

    task automatic test_period();
        do_reset();
        bus.coils = 4'b0001;
        wait_cycles(10);
        bus.coils = 4'b0010;
        expect_step(1'b1, 16'd1, 2'd1);
        wait_cycles(100);
        bus.coils = 4'b0100;
        expect_step(1'b1, 16'd2, 2'd2);
        wait_cycles(10);
        n_checks++; if (bus.step_period !== 20'd100) $display("FAIL step_period: got %0d, required 100", bus.step_period); else n_pass++;
        n_checks++; if (sb.size() !== 0) $display("FAIL period_missing: got %0d pending, required 0", sb.size()); else n_pass++;
    endtask

    task automatic test_reset_mid_filter();
        int p0;
        p0 = n_pulses;
        bus.coils = 4'b1000;
        wait_cycles(2);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.step_pulse, bus.dir, bus.position, bus.phase_idx, bus.enabled, bus.fault, bus.step_period} !== 42'd0)
            $display("FAIL midreset_outputs: got %0h, required 0",
                     {bus.step_pulse, bus.dir, bus.position, bus.phase_idx, bus.enabled, bus.fault, bus.step_period});
        else n_pass++;
        rst = 1'b0;
        wait_cycles(10);
        n_checks++; if (bus.enabled !== 1'b1 || bus.phase_idx !== 2'd3 || bus.position !== 16'd0 || n_pulses !== p0)
            $display("FAIL midreset_relock: got en=%0b idx=%0d pos=%0h pulses=%0d, required en=1 idx=3 pos=0 pulses=0",
                     bus.enabled, bus.phase_idx, bus.position, n_pulses - p0);
        else n_pass++;
    endtask

    initial begin
        bus.coils     = 4'b0000;
        bus.fault_clr = 1'b0;
        @(negedge clk);
        test_reset();
        test_lock();
        test_forward();
        test_reverse();
        test_bounce();
        test_fault();
        test_illegal();
        test_period();
        test_reset_mid_filter();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
